// File: rtl/bram_master_pkg.sv
// Shared state encoding and sizing helper for the BRAM initiator.
package bram_master_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RSP  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/bram_master.sv
// Initiator for a single-port BRAM: request/response streams
// plus a constant-value bulk fill engine.
import bram_master_pkg::*;

module bram_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [DATA_WIDTH-1:0] fill_val;
  logic                  in_idle;
  logic                  in_rsp;
  logic                  in_fill;
  logic                  fire;
  logic                  rd_fire;

  assign in_idle = (state == ST_IDLE);
  assign in_rsp  = (state == ST_RSP);
  assign in_fill = (state == ST_FILL);

  // fill_start outranks a same-cycle request while idle
  assign req_ready = !rst &&
                     ((in_idle && !fill_start) ||
                      (in_rsp && rsp_ready));
  assign fire    = req_valid && req_ready;
  assign rd_fire = fire && !req_write;

  assign mem_we    = !rst && (in_fill || (fire && req_write));
  assign mem_re    = rd_fire;
  assign mem_addr  = in_fill ? fill_cnt : req_addr;
  assign mem_wdata = in_fill ? fill_val : req_wdata;

  // BRAM output is stable while holding: no read issues in RSP
  assign rsp_valid = in_rsp;
  assign rsp_rdata = mem_rdata;
  assign fill_busy = in_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_addr  <= '0;
      fill_cnt  <= '0;
      fill_val  <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill_start) begin
            state    <= ST_FILL;
            fill_val <= fill_value;
            fill_cnt <= '0;
          end else if (rd_fire) begin
            state    <= ST_RSP;
            rsp_addr <= req_addr;
          end
        end
        ST_RSP: begin
          if (rd_fire) begin
            rsp_addr <= req_addr;
          end else if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
          if (fill_cnt == LAST) begin
            state     <= ST_IDLE;
            fill_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_master.sv
// Directed bench for bram_master driving a 16x8 BRAM model.
module tb_bram_master;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // BRAM model: 1-cycle synchronous read, contents cleared by reset
  logic [DW-1:0] mem [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (mem_we && mem_re) begin
        fails++;
        $display("FAIL excl: we=%b re=%b both set, need at most one", mem_we, mem_re);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    fill_start = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    rsp_ready  = 1'b1;
    fill_value = '0;
    req_valid  = 1'b1;
    fill_start = 1'b1;
    #3;
    tests++;
    if (req_ready !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      fails++;
      $display("FAIL rst_drive: ready=%b we=%b re=%b, need 0 0 0", req_ready, mem_we, mem_re);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_addr !== 4'd0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_state: rv=%b ra=%0d busy=%b done=%b, need 0 0 0 0",
               rsp_valid, rsp_addr, fill_busy, fill_done);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    drive_write(4'd3, 8'hA5);
    #1;
    tests++;
    if (req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_wdata !== 8'hA5) begin
      fails++;
      $display("FAIL wr_drive: ready=%b we=%b addr=%0d data=%h, need 1 1 3 a5",
               req_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    drive_read(4'd3);
    #1;
    tests++;
    if (mem_we !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 4'd3) begin
      fails++;
      $display("FAIL wr_once_rd_drive: we=%b re=%b addr=%0d, need 0 1 3", mem_we, mem_re, mem_addr);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_addr !== 4'd3) begin
      fails++;
      $display("FAIL rd_rsp: rv=%b data=%h addr=%0d, need 1 a5 3", rsp_valid, rsp_rdata, rsp_addr);
    end
    step();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rd_retire: rv=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive_write(AW'(i + 1), exp_d[i]);
      #1;
      tests++;
      if (req_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_wr%0d: ready=%b, need 1", i, req_ready);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_read(AW'(i + 1));
      else idle_inputs();
      #1;
      if (i < 3) begin
        tests++;
        if (req_ready !== 1'b1 || mem_re !== 1'b1) begin
          fails++;
          $display("FAIL b2b_rd%0d: ready=%b re=%b, need 1 1", i, req_ready, mem_re);
        end
      end
      if (i > 0) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[i-1] || rsp_addr !== AW'(i)) begin
          fails++;
          $display("FAIL b2b_rsp%0d: rv=%b data=%h addr=%0d, need 1 %h %0d",
                   i - 1, rsp_valid, rsp_rdata, rsp_addr, exp_d[i-1], i);
        end
      end
      step();
    end
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: rv=%b, need 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    drive_write(4'd3, 8'hA5);
    step();
    rsp_ready = 1'b0;
    drive_read(4'd3);
    step();
    drive_read(4'd1);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_addr !== 4'd3 ||
          req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: rv=%b data=%h addr=%0d ready=%b re=%b we=%b, need 1 a5 3 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_addr, req_ready, mem_re, mem_we);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1 || mem_re !== 1'b1 || rsp_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL bp_release: ready=%b re=%b data=%h, need 1 1 a5", req_ready, mem_re, rsp_rdata);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h11 || rsp_addr !== 4'd1) begin
      fails++;
      $display("FAIL bp_next: rv=%b data=%h addr=%0d, need 1 11 1", rsp_valid, rsp_rdata, rsp_addr);
    end
    step();
  endtask

  task automatic test_fill();
    int bad;
    fill_value = 8'h5A;
    fill_start = 1'b1;
    drive_read(4'd15);
    #1;
    tests++;
    if (req_ready !== 1'b0 || mem_re !== 1'b0) begin
      fails++;
      $display("FAIL fill_prio: ready=%b re=%b, need 0 0", req_ready, mem_re);
    end
    step();
    fill_start = 1'b0;
    fill_value = 8'h00;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (fill_busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(i) ||
          mem_wdata !== 8'h5A || req_ready !== 1'b0 || fill_done !== 1'b0) begin
        bad++;
        $display("FAIL fill_cyc%0d: busy=%b we=%b addr=%0d data=%h ready=%b done=%b, need 1 1 %0d 5a 0 0",
                 i, fill_busy, mem_we, mem_addr, mem_wdata, req_ready, fill_done, i);
      end
      step();
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0 || req_ready !== 1'b1 ||
        mem_re !== 1'b1 || mem_addr !== 4'd15) begin
      fails++;
      $display("FAIL fill_end: done=%b busy=%b ready=%b re=%b addr=%0d, need 1 0 1 1 15",
               fill_done, fill_busy, req_ready, mem_re, mem_addr);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (fill_done !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_addr !== 4'd15) begin
      fails++;
      $display("FAIL fill_rd: done=%b rv=%b data=%h addr=%0d, need 0 1 5a 15",
               fill_done, rsp_valid, rsp_rdata, rsp_addr);
    end
    step();
  endtask

  task automatic test_fill_priority();
    int n;
    int bad;
    fill_value = 8'h3C;
    fill_start = 1'b1;
    drive_read(4'd9);
    #1;
    tests++;
    if (req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL prio_start: ready=%b re=%b we=%b, need 0 0 0", req_ready, mem_re, mem_we);
    end
    step();
    fill_start = 1'b0;
    fill_value = 8'h00;
    n = 0;
    bad = 0;
    while (fill_done !== 1'b1 && n < 40) begin
      if (mem_re !== 1'b0 || mem_wdata !== 8'h3C) bad++;
      step();
      n++;
    end
    tests++;
    if (n != 16 || bad != 0) begin
      fails++;
      $display("FAIL prio_fill: cycles=%0d bad=%0d, need 16 0", n, bad);
    end
    tests++;
    if (req_ready !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 4'd9) begin
      fails++;
      $display("FAIL prio_accept: ready=%b re=%b addr=%0d, need 1 1 9", req_ready, mem_re, mem_addr);
    end
    step();
    idle_inputs();
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_addr !== 4'd9) begin
      fails++;
      $display("FAIL prio_rd: rv=%b data=%h addr=%0d, need 1 3c 9", rsp_valid, rsp_rdata, rsp_addr);
    end
    step();
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    fill_value = 8'hC3;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    tests++;
    if (fill_busy !== 1'b1 || mem_addr !== 4'd7) begin
      fails++;
      $display("FAIL mid_cnt: busy=%b addr=%0d, need 1 7", fill_busy, mem_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (fill_busy !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || req_ready !== 1'b0 ||
        rsp_valid !== 1'b0 || fill_done !== 1'b0 || rsp_addr !== 4'd0) begin
      fails++;
      $display("FAIL mid_rst: busy=%b we=%b re=%b ready=%b rv=%b done=%b ra=%0d, need all 0",
               fill_busy, mem_we, mem_re, req_ready, rsp_valid, fill_done, rsp_addr);
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_we !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_noresume: bad=%0d, need 0", bad);
    end
    drive_read(4'd7);
    step();
    idle_inputs();
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_addr !== 4'd7) begin
      fails++;
      $display("FAIL mid_rd: rv=%b data=%h addr=%0d, need 1 00 7", rsp_valid, rsp_rdata, rsp_addr);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_fill();
    test_fill_priority();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
